quad_decoder_multi: RTL

Parametrised multi-channel quadrature-encoder decoder; the generalised successor to the 4-bit state-action lookup in the encoder controller. Each channel synchronises and glitch-filters its A/B pair, classifies every filtered transition through a {previous AB, current AB} state-action table, and maintains a signed position counter with direction, step and error reporting. It sits between the encoder pins and the controller's position registers.

---
 rtl/quad_decoder_multi_if.sv | 25 ++
 rtl/quad_decoder_multi.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/quad_decoder_multi_if.sv
// Bus bundle between the encoder pins / position registers and quad_decoder_multi.
// Channel i of count lives at bits [i*CNT_W +: CNT_W].
interface quad_decoder_multi_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
);
    logic [CHANNELS-1:0]       enc_a;
    logic [CHANNELS-1:0]       enc_b;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS*CNT_W-1:0] count;
    logic [CHANNELS-1:0]       step;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       err;
    logic [CHANNELS-1:0]       err_sticky;

    modport master (
        output enc_a, enc_b, clr,
        input  count, step, dir, err, err_sticky
    );

    modport slave (
        input  enc_a, enc_b, clr,
        output count, step, dir, err, err_sticky
    );
endinterface

// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: per channel a 2-flop synchroniser, a
// run-length glitch filter, a {prev_ab, f} state-action table and a signed
// wrap-around position counter with step/dir/err reporting.
module quad_decoder_multi #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    quad_decoder_multi_if.slave  bus
);

    localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

    logic [CHANNELS-1:0][CNT_W-1:0] count_v;
    logic [CHANNELS-1:0]            step_v;
    logic [CHANNELS-1:0]            dir_v;
    logic [CHANNELS-1:0]            err_v;
    logic [CHANNELS-1:0]            sticky_v;

    assign bus.count      = count_v;
    assign bus.step       = step_v;
    assign bus.dir        = dir_v;
    assign bus.err        = err_v;
    assign bus.err_sticky = sticky_v;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]       sync1_r;
        logic [1:0]       sync2_r;
        // Filtered level; it also serves as prev_ab for the table lookup.
        logic [1:0]       filt_r;
        logic [1:0]       cand_r;
        logic [3:0]       run_r;
        logic             primed_r;
        logic [CNT_W-1:0] count_r;
        logic             step_r;
        logic             dir_r;
        logic             err_r;
        logic             sticky_r;

        logic             differs_s;
        logic             accept_s;
        logic [3:0]       run_nxt_s;
        logic [1:0]       cand_nxt_s;
        logic             fwd_s;
        logic             rev_s;
        logic             dbl_s;

        // Filter decision: count consecutive equal samples that differ from
        // the filtered level; before priming every level counts as new.
        always_comb begin
            differs_s  = (!primed_r) || (sync2_r != filt_r);
            accept_s   = 1'b0;
            run_nxt_s  = run_r;
            cand_nxt_s = cand_r;
            if (!differs_s) begin
                run_nxt_s = 4'd0;
            end else if ((run_r == 4'd0) || (sync2_r != cand_r)) begin
                cand_nxt_s = sync2_r;
                if (FILT_LEN_C == 4'd1) begin
                    accept_s  = 1'b1;
                    run_nxt_s = 4'd0;
                end else begin
                    run_nxt_s = 4'd1;
                end
            end else if ((run_r + 4'd1) == FILT_LEN_C) begin
                accept_s  = 1'b1;
                run_nxt_s = 4'd0;
            end else begin
                run_nxt_s = run_r + 4'd1;
            end
        end

        // State-action table indexed by {prev_ab, new filtered ab}.
        always_comb begin
            fwd_s = 1'b0;
            rev_s = 1'b0;
            dbl_s = 1'b0;
            case ({filt_r, sync2_r})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd_s = 1'b1;
                4'b0010, 4'b1011, 4'b1101, 4'b0100: rev_s = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: dbl_s = 1'b1;
                default: begin
                    fwd_s = 1'b0;
                    rev_s = 1'b0;
                    dbl_s = 1'b0;
                end
            endcase
        end

        // Synchroniser and filter state; reset discards in-flight progress.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_r  <= 2'b00;
                sync2_r  <= 2'b00;
                filt_r   <= 2'b00;
                cand_r   <= 2'b00;
                run_r    <= 4'd0;
                primed_r <= 1'b0;
            end else begin
                sync1_r <= {bus.enc_a[ch], bus.enc_b[ch]};
                sync2_r <= sync1_r;
                cand_r  <= cand_nxt_s;
                run_r   <= run_nxt_s;
                if (accept_s) begin
                    filt_r   <= sync2_r;
                    primed_r <= 1'b1;
                end
            end
        end

        // Counter and reporting; clr overrides any step or error this cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_r  <= '0;
                step_r   <= 1'b0;
                dir_r    <= 1'b0;
                err_r    <= 1'b0;
                sticky_r <= 1'b0;
            end else begin
                step_r <= 1'b0;
                err_r  <= 1'b0;
                if (accept_s && primed_r) begin
                    if (fwd_s) begin
                        dir_r <= 1'b1;
                        if (!bus.clr[ch]) begin
                            count_r <= count_r + CNT_W'(1);
                            step_r  <= 1'b1;
                        end
                    end else if (rev_s) begin
                        dir_r <= 1'b0;
                        if (!bus.clr[ch]) begin
                            count_r <= count_r - CNT_W'(1);
                            step_r  <= 1'b1;
                        end
                    end else if (dbl_s) begin
                        if (!bus.clr[ch]) begin
                            err_r    <= 1'b1;
                            sticky_r <= 1'b1;
                        end
                    end
                end
                if (bus.clr[ch]) begin
                    count_r  <= '0;
                    sticky_r <= 1'b0;
                end
            end
        end

        assign count_v[ch]  = count_r;
        assign step_v[ch]   = step_r;
        assign dir_v[ch]    = dir_r;
        assign err_v[ch]    = err_r;
        assign sticky_v[ch] = sticky_r;
    end

endmodule
